// File: rtl/key_debounce_encoder.sv
// Seven-key front end: two-flop synchronizer, tick-sampled debouncer per key,
// press pulses and a lowest-index-wins one-hot note enable for the tone blocks.
module key_debounce_encoder #(
  parameter int NKEYS        = 7,
  parameter int TICK_CYCLES  = 1_000_000,
  parameter int STABLE_TICKS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NKEYS-1:0] key_raw,
  output logic [NKEYS-1:0] key_held,
  output logic [NKEYS-1:0] press_pulse,
  output logic [NKEYS-1:0] note_en,
  output logic [2:0]       note_idx,
  output logic             note_valid
);

  localparam int PW = $clog2(TICK_CYCLES);
  localparam int SW = $clog2(STABLE_TICKS + 1);

  logic [NKEYS-1:0] s1_q, s2_q;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic             tick;
  logic [SW-1:0]    scnt_q [NKEYS];
  logic [SW-1:0]    scnt_d [NKEYS];
  logic [NKEYS-1:0] held_q, held_d;
  logic [NKEYS-1:0] pulse_q, pulse_d;
  logic [NKEYS-1:0] en_q, en_d;
  logic [2:0]       idx_q, idx_d;
  logic             valid_q, valid_d;

  assign tick   = (pcnt_q == PW'(TICK_CYCLES - 1));
  assign pcnt_d = tick ? '0 : pcnt_q + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NKEYS; gi++) begin : g_key
      logic differ;
      logic at_limit;
      assign differ   = s2_q[gi] ^ held_q[gi];
      assign at_limit = (scnt_q[gi] == SW'(STABLE_TICKS - 1));
      // Any agreeing sample, or a completed run, restarts the count.
      assign held_d[gi] = (tick && differ && at_limit) ? ~held_q[gi] : held_q[gi];
      assign scnt_d[gi] = !tick                  ? scnt_q[gi] :
                          (!differ || at_limit)  ? '0         :
                                                   scnt_q[gi] + 1'b1;
    end
  endgenerate

  assign pulse_d = held_d & ~held_q;

  // Encoder works on the next-state levels so it lands on the same edge as key_held.
  always_comb begin
    en_d  = '0;
    idx_d = '0;
    for (int k = NKEYS - 1; k >= 0; k--) begin
      if (held_d[k]) begin
        en_d    = '0;
        en_d[k] = 1'b1;
        idx_d   = 3'(k);
      end
    end
    valid_d = |en_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      pcnt_q  <= '0;
      held_q  <= '0;
      pulse_q <= '0;
      en_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      for (int k = 0; k < NKEYS; k++) scnt_q[k] <= '0;
    end else begin
      s1_q    <= key_raw;
      s2_q    <= s1_q;
      pcnt_q  <= pcnt_d;
      held_q  <= held_d;
      pulse_q <= pulse_d;
      en_q    <= en_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      for (int k = 0; k < NKEYS; k++) scnt_q[k] <= scnt_d[k];
    end
  end

  assign key_held    = held_q;
  assign press_pulse = pulse_q;
  assign note_en     = en_q;
  assign note_idx    = idx_q;
  assign note_valid  = valid_q;

endmodule
